reg_hist_display: RTL and testbench
===================================

# reg_hist_display

Downstream display stage for the 4-bit D-register: captures each new register output `Q` on a strobe into a 4-entry history and time-multiplexes the history onto the board's four-digit seven-segment display as hex digits. Digit 0 (rightmost) shows the newest value. Slots not yet filled are blanked. Sits between the register's `Q` and the board's `seg`/`an`/`dp` pins.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 2 to 2^20.
- `clk`  in  1  system clock, rising-edge.
- `clr`  in  1  asynchronous, active-high reset.
- `d_in`  in  4  value from the register's `Q`.
- `cap`  in  1  capture strobe, one cycle wide; sampled every rising edge.
- `seg`  out  7  cathodes, active-low, bit order `{g,f,e,d,c,b,a}`.
- `dp`  out  1  decimal point, active-low.
- `an`  out  4  anodes, active-low, `an[0]` is the rightmost digit.
- `hist_cnt`  out  3  number of valid history entries, 0..4.

## Operation
- History registers `h0`..`h3`, each 4 bits. On `cap`=1 the history shifts: `h3<=h2`, `h2<=h1`, `h1<=h0`, `h0<=d_in`. `hist_cnt` increments and saturates at 4. The oldest entry is dropped once the history is full.
- Divider `div` counts from 0 to REFRESH_DIV-1 and wraps. The terminal count produces a one-cycle `tick`.
- Scan FSM: states SCAN0 → SCAN1 → SCAN2 → SCAN3 → SCAN0, advancing only on `tick`. In state SCANk, digit k shows `hk`.
- Digit k is lit only when k < `hist_cnt`. Otherwise `an` is 4'b1111 for that slot and `seg` is 7'b1111111.
- Hex decode, active-low:
  - 0 = 1000000
  - 3 = 0110000
  - 5 = 0010010
  - A = 0001000
  - F = 0001110
  - All 16 codes are decoded; there are no illegal codes.
- `dp` is 0 only while digit 0 is lit (marks the newest value). Otherwise it is 1.
- A `cap` in the same cycle as `tick` performs both the capture and the scan advance.

## Timing
- Reset values, applied asynchronously while `clr`=1:
  - `div`=0, state SCAN0, `h0`..`h3`=0, `hist_cnt`=0.
  - `an`=4'b1111, `seg`=7'b1111111, `dp`=1.
- `seg`, `an` and `dp` are registered. At edge n they take values computed from the state, history and `hist_cnt` present before edge n, so they lag one cycle behind the FSM/history.
- Capture latency:
  - `cap` sampled at edge n updates the history and `hist_cnt` at edge n.
  - The new value appears on digit 0 at edge n+1, provided the FSM is in SCAN0 at that point; otherwise it appears at the next SCAN0 slot.
- Each digit is driven for exactly REFRESH_DIV cycles; a full frame is 4×REFRESH_DIV cycles.
- `clr` asserted mid-scan or mid-capture overrides everything immediately: outputs blank with no clock needed. Operation resumes in SCAN0 with `div`=0 at the first edge after `clr` drops.
- `cap` held high for m cycles captures m times. This is legal, not filtered.

## Configuration
- `DUP_SUPPRESS_EN` defined:
  - A `cap` with `hist_cnt`>0 and `d_in`==`h0` is ignored: no shift, and `hist_cnt` is unchanged.
  - With `hist_cnt`=0, a capture always happens.
- `DUP_SUPPRESS_EN` undefined: every `cap` shifts the history, duplicates included.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset: assert `clr` asynchronously mid-cycle → `an`=1111, `seg`=1111111, `dp`=1 and `hist_cnt`=0 immediately, before any clock edge.
- Single capture:
  - Stimulus: `d_in`=5, `cap` pulse, then observe one frame.
  - Required: `hist_cnt`=1; during the SCAN0 slot `an`=1110, `seg`=0010010, `dp`=0; the other three slots are blank (`an`=1111).
- Fill and overflow:
  - Stimulus: capture 3, A, F, 0, 5 in sequence.
  - Required: `hist_cnt` saturates at 4; digits 0..3 show 5, 0, F, A; the value 3 is dropped.
- Scan cadence: after the history is full, `an` follows 1110 → 1101 → 1011 → 0111 → 1110, each pattern held exactly 4 cycles.
- Simultaneous events: `cap` asserted on the `tick` cycle → both the shift and the digit advance occur at that same edge.
- Duplicate values:
  - Stimulus: capture 3, then capture 3 again.
  - With `DUP_SUPPRESS_EN` defined: `hist_cnt`=1.
  - Without it: `hist_cnt`=2, and digits 0 and 1 both show 3.
- Reset mid-frame: pulse `clr` during SCAN2 → blank immediately; after release, history is empty and scanning restarts at SCAN0 with all slots blank.

Source files
------------

// File: rtl/reg_hist_display.sv
// rtl/reg_hist_display.sv - capture history of the D-register output and scan it onto a 4-digit seven-segment display
// Optional build macro: DUP_SUPPRESS_EN (ignore a capture that repeats the newest entry)
module reg_hist_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] d_in,
    input  logic       cap,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic [2:0] hist_cnt
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic [1:0] {
        SCAN0 = 2'd0,
        SCAN1 = 2'd1,
        SCAN2 = 2'd2,
        SCAN3 = 2'd3
    } scan_t;

    scan_t            state;
    scan_t            state_nxt;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic             do_cap;

    logic [3:0] h0;
    logic [3:0] h1;
    logic [3:0] h2;
    logic [3:0] h3;

    logic [1:0] digit_idx;
    logic [3:0] digit_val;
    logic       digit_lit;
    logic [6:0] seg_nxt;
    logic [3:0] an_nxt;
    logic       dp_nxt;

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}; every nibble has a glyph.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign tick = (div == DIV_LAST);

`ifdef DUP_SUPPRESS_EN
    // A repeat of the newest value is dropped, but an empty history always accepts.
    assign do_cap = cap && !((hist_cnt != 3'd0) && (d_in == h0));
`else
    assign do_cap = cap;
`endif

    // Refresh divider: one tick per digit slot, wrapping at REFRESH_DIV-1.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Scan state register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= SCAN0;
        end else begin
            state <= state_nxt;
        end
    end

    // Scan next-state plus the digit image for the current slot.
    always_comb begin
        state_nxt = state;
        digit_idx = 2'd0;
        digit_val = 4'h0;
        digit_lit = 1'b0;
        seg_nxt   = SEG_BLANK;
        an_nxt    = AN_OFF;
        dp_nxt    = 1'b1;

        case (state)
            SCAN0: begin
                digit_idx = 2'd0;
                digit_val = h0;
                if (tick) state_nxt = SCAN1;
            end
            SCAN1: begin
                digit_idx = 2'd1;
                digit_val = h1;
                if (tick) state_nxt = SCAN2;
            end
            SCAN2: begin
                digit_idx = 2'd2;
                digit_val = h2;
                if (tick) state_nxt = SCAN3;
            end
            SCAN3: begin
                digit_idx = 2'd3;
                digit_val = h3;
                if (tick) state_nxt = SCAN0;
            end
            default: begin
                state_nxt = SCAN0;
            end
        endcase

        // Only slots already holding a captured value are lit.
        digit_lit = ({1'b0, digit_idx} < hist_cnt);

        if (digit_lit) begin
            seg_nxt = hex7(digit_val);
            an_nxt  = ~(4'b0001 << digit_idx);
            dp_nxt  = (digit_idx != 2'd0);
        end
    end

    // History shift register: newest in h0, oldest falls off h3 when full.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            h0 <= 4'h0;
            h1 <= 4'h0;
            h2 <= 4'h0;
            h3 <= 4'h0;
        end else if (do_cap) begin
            h3 <= h2;
            h2 <= h1;
            h1 <= h0;
            h0 <= d_in;
        end
    end

    // Valid-entry count, saturating at four.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hist_cnt <= 3'd0;
        end else if (do_cap && (hist_cnt != 3'd4)) begin
            hist_cnt <= hist_cnt + 3'd1;
        end
    end

    // Registered pin drivers, one cycle behind the scan state and history.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            seg <= SEG_BLANK;
            an  <= AN_OFF;
            dp  <= 1'b1;
        end else begin
            seg <= seg_nxt;
            an  <= an_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_reg_hist_display.sv
// tb/tb_reg_hist_display.sv - directed self-checking bench for reg_hist_display
module tb_reg_hist_display;

    localparam int RDIV = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic       clk  = 1'b0;
    logic       clr  = 1'b0;
    logic [3:0] d_in = 4'h0;
    logic       cap  = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [2:0] hist_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] exp_seg [4] = '{SEG_5, SEG_0, SEG_F, SEG_A};
    logic       exp_dp  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    reg_hist_display #(.REFRESH_DIV(RDIV)) dut (
        .clk      (clk),
        .clr      (clr),
        .d_in     (d_in),
        .cap      (cap),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .hist_cnt (hist_cnt)
    );

    always #5 clk = ~clk;

    // Rising edges since clr last dropped.
    always @(posedge clk or posedge clr) begin
        if (clr) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    task automatic chk_an(input string tag, input logic [3:0] exp);
        n_assert++;
        assert (an === exp) else begin
            n_fail++;
            $error("FAIL %s an: observed %b expected %b", tag, an, exp);
        end
    endtask

    task automatic chk_seg(input string tag, input logic [6:0] exp);
        n_assert++;
        assert (seg === exp) else begin
            n_fail++;
            $error("FAIL %s seg: observed %b expected %b", tag, seg, exp);
        end
    endtask

    task automatic chk_dp(input string tag, input logic exp);
        n_assert++;
        assert (dp === exp) else begin
            n_fail++;
            $error("FAIL %s dp: observed %b expected %b", tag, dp, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [2:0] exp);
        n_assert++;
        assert (hist_cnt === exp) else begin
            n_fail++;
            $error("FAIL %s hist_cnt: observed %0d expected %0d", tag, hist_cnt, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
        chk_an(tag, e_an);
        chk_seg(tag, e_seg);
        chk_dp(tag, e_dp);
    endtask

    // Advance to the falling edge that follows rising edge k after clr release.
    task automatic goto(input int k);
        int guard;
        guard = 0;
        while (edge_n < k && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_assert++;
        assert (edge_n == k) else begin
            n_fail++;
            $error("FAIL goto edge: observed %0d expected %0d", edge_n, k);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #2 clr = 1'b1;
        #1;
        chk_disp("reset_async", 4'b1111, SEG_BLANK, 1'b1);
        chk_cnt("reset_async", 3'd0);
        @(negedge clk);
        chk_disp("reset_held", 4'b1111, SEG_BLANK, 1'b1);
        @(negedge clk);
        clr = 1'b0;

        // Single capture of 5 at edge 1.
        d_in = 4'h5;
        cap  = 1'b1;
        goto(1);
        cap = 1'b0;
        chk_cnt("single_cnt", 3'd1);
        chk_an("single_lag", 4'b1111);
        goto(2);
        chk_disp("single_d0", 4'b1110, SEG_5, 1'b0);
        goto(5);
        chk_disp("single_s1", 4'b1111, SEG_BLANK, 1'b1);
        goto(9);
        chk_an("single_s2", 4'b1111);
        goto(13);
        chk_an("single_s3", 4'b1111);
        goto(17);
        chk_disp("single_frame2", 4'b1110, SEG_5, 1'b0);

        // Fill and overflow: 3, A, F, 0, 5 on edges 21..25.
        goto(20);
        d_in = 4'h3;
        cap  = 1'b1;
        goto(21);
        chk_cnt("fill_cnt2", 3'd2);
        d_in = 4'hA;
        goto(22);
        chk_cnt("fill_cnt3", 3'd3);
        d_in = 4'hF;
        goto(23);
        chk_cnt("fill_cnt4", 3'd4);
        d_in = 4'h0;
        goto(24);
        d_in = 4'h5;
        goto(25);
        cap = 1'b0;
        chk_cnt("fill_sat", 3'd4);

        // Cadence with full history: digits show 5, 0, F, A, each for 4 cycles.
        goto(32);
        chk_disp("cad_pre", 4'b0111, SEG_A, 1'b1);
        for (int j = 0; j < 4; j++) begin
            for (int r = 0; r < 4; r++) begin
                goto(33 + 4 * j + r);
                chk_an($sformatf("cad_s%0d_c%0d", j, r), exp_an[j]);
                if (r == 0) begin
                    chk_seg($sformatf("cad_s%0d", j), exp_seg[j]);
                    chk_dp($sformatf("cad_s%0d", j), exp_dp[j]);
                end
            end
        end
        goto(49);
        chk_disp("cad_wrap", 4'b1110, SEG_5, 1'b0);

        // Capture of 3 on the tick edge 52 (SCAN0 -> SCAN1).
        goto(51);
        d_in = 4'h3;
        cap  = 1'b1;
        goto(52);
        cap = 1'b0;
        chk_cnt("simul_cnt", 3'd4);
        chk_disp("simul_lag", 4'b1110, SEG_5, 1'b0);
        goto(53);
        chk_disp("simul_adv", 4'b1101, SEG_5, 1'b1);

        // clr pulsed while SCAN2 is on the pins (history 3,5,0,F).
        goto(58);
        chk_disp("pre_clr_s2", 4'b1011, SEG_0, 1'b1);
        #2 clr = 1'b1;
        #1;
        chk_disp("clr_mid", 4'b1111, SEG_BLANK, 1'b1);
        chk_cnt("clr_mid", 3'd0);
        @(negedge clk);
        chk_disp("clr_held", 4'b1111, SEG_BLANK, 1'b1);
        clr = 1'b0;
        goto(1);
        chk_cnt("post_clr_e1", 3'd0);
        chk_disp("post_clr_e1", 4'b1111, SEG_BLANK, 1'b1);
        d_in = 4'hA;
        cap  = 1'b1;
        goto(2);
        cap = 1'b0;
        chk_cnt("post_clr_cap", 3'd1);
        chk_an("post_clr_lag", 4'b1111);
        goto(3);
        chk_disp("post_clr_s0", 4'b1110, SEG_A, 1'b0);
        goto(5);
        chk_an("post_clr_s1", 4'b1111);

        // Duplicate captures of 3 on edges 1 and 2 after a fresh clr.
        clr = 1'b1;
        #1;
        chk_cnt("dup_clr", 3'd0);
        @(negedge clk);
        clr  = 1'b0;
        d_in = 4'h3;
        cap  = 1'b1;
        goto(2);
        cap = 1'b0;
`ifdef DUP_SUPPRESS_EN
        chk_cnt("dup_cnt", 3'd1);
`else
        chk_cnt("dup_cnt", 3'd2);
`endif
        goto(3);
        chk_disp("dup_d0", 4'b1110, SEG_3, 1'b0);
        goto(5);
`ifdef DUP_SUPPRESS_EN
        chk_disp("dup_d1", 4'b1111, SEG_BLANK, 1'b1);
`else
        chk_disp("dup_d1", 4'b1101, SEG_3, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
